// File: rtl/mul_div_unit_if.sv
// Handshake bundle between the EXE stage and the multi-cycle multiply/divide unit.
// The master issues requests and consumes results; the slave is the unit itself.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, src1, src2, cancel, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, cancel, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MUL.W/MULH.W/MULH.WU and DIV.W/MOD.W/DIV.WU/MOD.WU unit.
// Fixed-latency multiply, radix-2 restoring divide with a separate sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    neg_if = neg ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             mul_lo_q, mul_lo_d;
  logic             mul_sgn_q, mul_sgn_d;
  logic             div_quo_q, div_quo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic               accept_s;
  logic               div_sgn_s;
  logic [2*WIDTH-1:0] ma_s, mb_s, prod_s;
  logic [WIDTH+1:0]   diff_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

  assign accept_s  = bus.in_valid & (state_q == S_IDLE) & ~bus.cancel & (bus.op != 7'd0);
  assign div_sgn_s = bus.op[3] | bus.op[4];

  // Operands extended to 2*WIDTH so the low 2*WIDTH product bits are exact for both signednesses.
  assign ma_s   = {{WIDTH{mul_sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mb_s   = {{WIDTH{mul_sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod_s = ma_s * mb_s;

  assign diff_s    = {rem_q, quo_q[WIDTH-1]} - {2'b00, b_q};
  assign quo_fix_s = (b_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : neg_if(quo_q, qneg_q);
  assign rem_fix_s = neg_if(rem_q[WIDTH-1:0], rneg_q);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;

  // Next-state and datapath update; cancel overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    mul_lo_d  = mul_lo_q;
    mul_sgn_d = mul_sgn_q;
    div_quo_d = div_quo_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    if ((state_q != S_IDLE) && bus.cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            cnt_d     = {CW{1'b0}};
            mul_lo_d  = bus.op[0];
            mul_sgn_d = bus.op[0] | bus.op[1];
            div_quo_d = bus.op[3] | bus.op[5];
            if (|bus.op[2:0]) begin
              state_d = S_MUL;
              a_d     = bus.src1;
              b_d     = bus.src2;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
            end else begin
              state_d = S_DIV;
              a_d     = neg_if(bus.src1, div_sgn_s & bus.src1[WIDTH-1]);
              b_d     = neg_if(bus.src2, div_sgn_s & bus.src2[WIDTH-1]);
              qneg_d  = div_sgn_s & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
              rneg_d  = div_sgn_s & bus.src1[WIDTH-1];
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d  = S_DONE;
            result_d = mul_lo_q ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DIV: begin
          // Count 0 loads the shift registers; counts 1..WIDTH each retire one quotient bit.
          if (cnt_q == {CW{1'b0}}) begin
            rem_d = {(WIDTH+1){1'b0}};
            quo_d = a_q;
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            if (!diff_s[WIDTH+1]) begin
              rem_d = diff_s[WIDTH:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == DIV_LAST) begin
              state_d = S_FIX;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        S_FIX: begin
          state_d  = S_DONE;
          result_d = div_quo_q ? quo_fix_s : rem_fix_s;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      rem_q     <= {(WIDTH+1){1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      mul_lo_q  <= 1'b0;
      mul_sgn_q <= 1'b0;
      div_quo_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mul_lo_q  <= mul_lo_d;
      mul_sgn_q <= mul_sgn_d;
      div_quo_q <= div_quo_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases, backpressure, cancel,
// mid-operation reset and randomized traffic checked against an arithmetic model.
module tb_mul_div_unit;
  localparam int W  = 32;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          xfers  = 0;
  logic        vprev  = 1'b0;
  logic [31:0] held   = 32'd0;
  bit          rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input int opi, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    case (opi)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = ua * ub; return p[63:32]; end
      3: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      4: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      6: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: latency on out_valid rise, stability while stalled, result on each transfer.
  always @(negedge clk) begin
    if (reset) begin
      vprev <= 1'b0;
    end else begin
      if (bus.out_valid && !vprev) begin
        if (sb_q.size() == 0) chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
        else                  chk("latency", 32'(cyc - sb_q[0].t), 32'(sb_q[0].lat));
      end
      if (bus.out_valid && vprev) chk("hold_result", bus.result, held);
      if (bus.out_valid)          chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready && !bus.cancel && sb_q.size() > 0) begin
        chk("result", bus.result, sb_q[0].res);
        void'(sb_q.pop_front());
        xfers <= xfers + 1;
      end
      vprev <= bus.out_valid;
      held  <= bus.result;
    end
  end

  task automatic issue(input int opi, input logic [31:0] a, input logic [31:0] b, input bit push);
    int   n = 0;
    exp_t e;
    while (!bus.in_ready && n < 300) begin
      if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      chk("issue_timeout", 32'(n), 32'd0);
    end else begin
      bus.in_valid = 1'b1;
      bus.op       = 7'(1 << opi);
      bus.src1     = a;
      bus.src2     = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op       = 7'd0;
      if (push) begin
        e.res = ref_res(opi, a, b);
        e.lat = (opi < 3) ? ML : W + 2;
        e.t   = cyc;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sb_q.size() != 0 || !bus.in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    int sel = $urandom_range(0, 7);
    case (sel)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int x0;
    int n;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 7'd0;
    bus.src1      = 32'd0;
    bus.src2      = 32'd0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(0, 32'hFFFF_FFFF, 32'h2, 1);
    issue(1, 32'hFFFF_FFFF, 32'h2, 1);
    issue(2, 32'hFFFF_FFFF, 32'h2, 1);
    issue(3, 32'hFFFF_FFF9, 32'h2, 1);
    issue(4, 32'hFFFF_FFF9, 32'h2, 1);
    issue(5, 32'hFFFF_FFF9, 32'h2, 1);
    issue(6, 32'hFFFF_FFF9, 32'h2, 1);
    issue(3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(5, 32'd5, 32'd0, 1);
    issue(6, 32'd5, 32'd0, 1);
    issue(3, 32'hFFFF_FFFB, 32'd0, 1);
    issue(4, 32'hFFFF_FFFB, 32'd0, 1);
    drain();

    // Backpressure: five stalled cycles, then exactly one transfer.
    bus.out_ready = 1'b0;
    x0 = xfers;
    issue(5, 32'd100, 32'd3, 1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bp_no_xfer", 32'(xfers), 32'(x0));
    chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_one_xfer", 32'(xfers), 32'(x0 + 1));
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("bp_still_one", 32'(xfers), 32'(x0 + 1));

    // Cancel while idle must block the request.
    bus.cancel   = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 7'd1;
    bus.src1     = 32'd9;
    bus.src2     = 32'd9;
    @(posedge clk); #1;
    bus.cancel   = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 7'd0;
    chk("idle_cancel_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle_cancel_no_valid", 32'(bus.out_valid), 32'd0);

    // Cancel a division part way through; nothing may come out.
    issue(3, 32'd100, 32'd7, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("cancel_out_valid", 32'(bus.out_valid), 32'd0);
    issue(0, 32'd3, 32'd4, 1);
    drain();

    // Reset in the middle of a division.
    issue(3, 32'hFFFF_0000, 32'd13, 0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midreset_result", bus.result, 32'd0);
    issue(5, 32'd100, 32'd7, 1);
    drain();

    // Randomized traffic with random consumer stalls.
    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue($urandom_range(0, 6), rnd_operand(), rnd_operand(), 1);
    end
    rnd_bp = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
